// File: rtl/donut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : donut_pkg
// Description : Frame geometry and ROM addressing constants shared by the
//               address generator, frame ROM and colour-mapping stage.
// Revision    : 1.0 - initial release
// ============================================================================
package donut_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 440;
    localparam int FRAMES      = 60;
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
    localparam int ROM_DEPTH   = FRAMES * FRAME_WORDS;
    localparam int ADDR_W      = 32;

    localparam int IDX_W = 6;
    localparam int OFF_W = 19;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage
`default_nettype wire

// File: rtl/donut_frame_seq.sv
`default_nettype none
// ============================================================================
// Module      : donut_frame_seq
// Description : Animation frame stepper: display-frame divider, frame index
//               and ROM frame base address, with pause and wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module donut_frame_seq #(
    parameter int FRAMES      = donut_pkg::FRAMES,
    parameter int FRAME_WORDS = donut_pkg::FRAME_WORDS,
    parameter int FRAME_DIV   = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           frame_start_i,
    input  logic                           pause_i,
    output logic [donut_pkg::IDX_W-1:0]    frame_idx_o,
    output logic [donut_pkg::ADDR_W-1:0]   frame_base_o
);
    import donut_pkg::*;

    localparam int                 c_div_w    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(FRAME_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
    localparam logic [IDX_W-1:0]   c_idx_last = IDX_W'(FRAMES - 1);
    localparam logic [IDX_W-1:0]   c_idx_one  = IDX_W'(1);
    localparam addr_t              c_step     = addr_t'(FRAME_WORDS);

    logic [c_div_w-1:0] r_div_cnt;
    logic [IDX_W-1:0]   r_frame_idx;
    addr_t              r_frame_base;

    // Base steps by a constant increment so no multiplier is needed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div_cnt    <= '0;
            r_frame_idx  <= '0;
            r_frame_base <= '0;
        end else if (frame_start_i && !pause_i) begin
            if (r_div_cnt == c_div_last) begin
                r_div_cnt <= '0;
                if (r_frame_idx == c_idx_last) begin
                    r_frame_idx  <= '0;
                    r_frame_base <= '0;
                end else begin
                    r_frame_idx  <= r_frame_idx + c_idx_one;
                    r_frame_base <= r_frame_base + c_step;
                end
            end else begin
                r_div_cnt <= r_div_cnt + c_div_one;
            end
        end
    end

    assign frame_idx_o  = r_frame_idx;
    assign frame_base_o = r_frame_base;

endmodule
`default_nettype wire

// File: rtl/donut_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : donut_addr_gen
// Description : Donut frame ROM read-address sequencer with window decode,
//               pixel offset counter and ROM-latency-matched valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module donut_addr_gen #(
    parameter int H_ACTIVE    = donut_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = donut_pkg::V_ACTIVE,
    parameter int V_OFFSET    = 20,
    parameter int FRAMES      = donut_pkg::FRAMES,
    parameter int FRAME_WORDS = donut_pkg::FRAME_WORDS,
    parameter int FRAME_DIV   = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           frame_start_i,
    input  logic                           de_i,
    input  logic [9:0]                     pix_x_i,
    input  logic [9:0]                     pix_y_i,
    input  logic                           pause_i,
    output logic [donut_pkg::ADDR_W-1:0]   addr_rd_o,
    output logic                           cen_o,
    output logic                           valid_o,
    output logic [donut_pkg::IDX_W-1:0]    frame_idx_o,
    output logic                           err_o
);
    import donut_pkg::*;

    localparam logic [10:0]      c_x_end    = 11'(H_ACTIVE);
    localparam logic [10:0]      c_y_beg    = 11'(V_OFFSET);
    localparam logic [10:0]      c_y_end    = 11'(V_OFFSET + V_ACTIVE);
    localparam logic [OFF_W-1:0] c_off_last = OFF_W'(FRAME_WORDS - 1);
    localparam logic [OFF_W-1:0] c_off_one  = OFF_W'(1);

    logic             w_win;
    addr_t            w_base;
    logic [OFF_W-1:0] w_off_use;
    logic [OFF_W-1:0] r_pix_off;
    logic             r_full;
    logic             r_cen;
    logic             r_valid;
    logic             r_err;
    addr_t            r_addr;

    assign w_win = de_i
                && ({1'b0, pix_x_i} <  c_x_end)
                && ({1'b0, pix_y_i} >= c_y_beg)
                && ({1'b0, pix_y_i} <  c_y_end);

    // A pixel coinciding with frame_start belongs to the new display frame.
    assign w_off_use = frame_start_i ? '0 : r_pix_off;

    donut_frame_seq #(
        .FRAMES      (FRAMES),
        .FRAME_WORDS (FRAME_WORDS),
        .FRAME_DIV   (FRAME_DIV)
    ) u_frame_seq (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .frame_start_i (frame_start_i),
        .pause_i       (pause_i),
        .frame_idx_o   (frame_idx_o),
        .frame_base_o  (w_base)
    );

    // r_full marks that the last word has been issued, so the error flags
    // only a pixel beyond FRAME_WORDS, not the final legitimate one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pix_off <= '0;
            r_full    <= 1'b0;
            r_cen     <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_cen   <= w_win;
            r_valid <= r_cen;
            if (w_win) begin
                r_addr <= w_base + addr_t'(w_off_use);
            end
            if (frame_start_i) begin
                r_pix_off <= w_win ? c_off_one : '0;
                r_full    <= 1'b0;
            end else if (w_win) begin
                if (r_pix_off != c_off_last) begin
                    r_pix_off <= r_pix_off + c_off_one;
                end else if (r_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_full <= 1'b1;
                end
            end
        end
    end

    assign addr_rd_o = r_addr;
    assign cen_o     = r_cen;
    assign valid_o   = r_valid;
    assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_donut_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_donut_addr_gen
// Description : Self-checking bench for donut_addr_gen (default geometry plus
//               a reduced geometry instance for full-frame and overflow runs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_donut_addr_gen;

    logic       clk = 1'b0;
    logic       rst, fs, de, pause;
    logic [9:0] px, py;

    logic [31:0] a_addr, b_addr;
    logic        a_cen, a_valid, a_err, b_cen, b_valid, b_err;
    logic [5:0]  a_idx, b_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    donut_addr_gen u_dut_a (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_start_i (fs),
        .de_i          (de),
        .pix_x_i       (px),
        .pix_y_i       (py),
        .pause_i       (pause),
        .addr_rd_o     (a_addr),
        .cen_o         (a_cen),
        .valid_o       (a_valid),
        .frame_idx_o   (a_idx),
        .err_o         (a_err)
    );

    // 8x4 image starting on line 2, 3 frames of 32 words, step every frame.
    donut_addr_gen #(
        .H_ACTIVE    (8),
        .V_ACTIVE    (4),
        .V_OFFSET    (2),
        .FRAMES      (3),
        .FRAME_WORDS (32),
        .FRAME_DIV   (1)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_start_i (fs),
        .de_i          (de),
        .pix_x_i       (px),
        .pix_y_i       (py),
        .pause_i       (pause),
        .addr_rd_o     (b_addr),
        .cen_o         (b_cen),
        .valid_o       (b_valid),
        .frame_idx_o   (b_idx),
        .err_o         (b_err)
    );

    typedef struct {
        logic rst;
        logic fs;
        logic de;
        int   x;
        int   y;
        logic pause;
        int   addr;
        logic cen;
        logic valid;
        int   idx;
        logic err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic d,
                         input int x, input int y, input logic p);
        rst   = r;
        fs    = f;
        de    = d;
        px    = 10'(x);
        py    = 10'(y);
        pause = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic f, input logic d, input int x, input int y,
                       input logic p, input int ad, input logic c, input logic v,
                       input int ix, input logic e);
        vec_t t;
        t.rst = r; t.fs = f; t.de = d; t.x = x; t.y = y; t.pause = p;
        t.addr = ad; t.cen = c; t.valid = v; t.idx = ix; t.err = e;
        vecs.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic exp_win;

        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

        //   rst fs de   x    y  pause  addr    cen valid idx err
        add(1, 1, 1,   5,  30, 0,       0,      0, 0,    0,  0);
        add(1, 0, 1,   0,  20, 1,       0,      0, 0,    0,  0);
        add(1, 1, 1, 300, 200, 0,       0,      0, 0,    0,  0);
        add(0, 0, 0,   0,   0, 0,       0,      0, 0,    0,  0);
        add(0, 0, 0,   0,   0, 0,       0,      0, 0,    0,  0);
        add(0, 1, 0,   0,   0, 0,       0,      0, 0,    0,  0);
        add(0, 0, 1,   0,  20, 0,       0,      1, 0,    0,  0);
        add(0, 0, 1,   1,  20, 0,       1,      1, 1,    0,  0);
        add(0, 0, 1, 640,  20, 0,       1,      0, 1,    0,  0);
        add(0, 0, 1,   2,  19, 0,       1,      0, 0,    0,  0);
        add(0, 0, 0,   3,  20, 0,       1,      0, 0,    0,  0);
        add(0, 0, 1, 639, 459, 0,       2,      1, 0,    0,  0);
        add(0, 0, 1,   0, 460, 0,       2,      0, 1,    0,  0);
        add(0, 1, 0,   0,   0, 0,       2,      0, 0,    1,  0);
        add(0, 0, 1,   0,  20, 0,  281600,      1, 0,    1,  0);
        add(0, 1, 1,   5, 100, 0,  281600,      1, 1,    1,  0);
        add(0, 0, 1,   6, 100, 0,  281601,      1, 1,    1,  0);
        add(0, 1, 1,   7, 100, 0,  281600,      1, 1,    2,  0);
        add(0, 0, 1,   8, 100, 0,  563201,      1, 1,    2,  0);
        add(0, 1, 0,   0,   0, 1,  563201,      0, 1,    2,  0);
        add(0, 1, 0,   0,   0, 1,  563201,      0, 0,    2,  0);
        add(0, 0, 1,   0,  20, 1,  563200,      1, 0,    2,  0);
        add(0, 1, 0,   0,   0, 0,  563200,      0, 1,    2,  0);
        add(0, 1, 0,   0,   0, 0,  563200,      0, 0,    3,  0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].fs, vecs[i].de, vecs[i].x, vecs[i].y, vecs[i].pause);
            tick();
            check($sformatf("v%0d addr", i),  a_addr,        32'(vecs[i].addr));
            check($sformatf("v%0d cen", i),   32'(a_cen),    32'(vecs[i].cen));
            check($sformatf("v%0d valid", i), 32'(a_valid),  32'(vecs[i].valid));
            check($sformatf("v%0d idx", i),   32'(a_idx),    32'(vecs[i].idx));
            check($sformatf("v%0d err", i),   32'(a_err),    32'(vecs[i].err));
        end

        // Divider, pause at frame 7 and wrap after frame 59.
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        tick(); tick();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        tick();
        for (int p = 1; p <= 14; p++) begin
            drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
            tick();
            check($sformatf("step%0d idx", p), 32'(a_idx), 32'(p / 2));
            drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
            tick();
            check($sformatf("pause%0d idx", k), 32'(a_idx), 32'd7);
            drive(1'b0, 1'b0, 1'b1, 0, 20, 1'b1);
            tick();
            check($sformatf("pause%0d addr", k), a_addr, 32'd1971200);
        end
        for (int p = 15; p <= 120; p++) begin
            drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
            tick();
            check($sformatf("step%0d idx", p), 32'(a_idx), 32'((p / 2) % 60));
            drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 0, 20, 1'b0);
        tick();
        check("wrap addr", a_addr, 32'd0);
        check("wrap cen", 32'(a_cen), 32'd1);

        // Full raster on the reduced instance: 10x8 scan with 8x4 window.
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        tick(); tick();
        cnt = 0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 10; x++) begin
                exp_win = (x < 8) && (y >= 2) && (y < 6);
                drive(1'b0, 1'b0, 1'b1, x, y, 1'b0);
                tick();
                check($sformatf("raster x%0d y%0d cen", x, y), 32'(b_cen), 32'(exp_win));
                if (exp_win) begin
                    check($sformatf("raster x%0d y%0d addr", x, y), b_addr, 32'(cnt));
                    cnt++;
                end
            end
        end
        check("raster last addr", b_addr, 32'd31);
        check("raster err", 32'(b_err), 32'd0);
        check("raster idx before", 32'(b_idx), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        tick();
        check("raster idx after", 32'(b_idx), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 0, 2, 1'b0);
        tick();
        check("next frame first addr", b_addr, 32'd32);

        // Overflow: 33 in-window pixels in one display frame.
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        tick(); tick();
        for (int k = 1; k <= 33; k++) begin
            drive(1'b0, 1'b0, 1'b1, 0, 2, 1'b0);
            tick();
            check($sformatf("ovf%0d addr", k), b_addr, 32'((k > 32) ? 31 : k - 1));
            check($sformatf("ovf%0d err", k), 32'(b_err), 32'(k == 33));
        end
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        tick(); tick(); tick();
        check("err sticky idle", 32'(b_err), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        tick();
        check("err sticky frame_start", 32'(b_err), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 0, 2, 1'b0);
        tick();
        check("err new frame addr", b_addr, 32'd32);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        tick();
        check("err cleared by reset", 32'(b_err), 32'd0);
        check("idx cleared by reset", 32'(b_idx), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
